// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM states, port ids and default widths for the SRAM arbiter
package sram_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
endpackage

// File: rtl/sram_rr_arb2.sv
// sram_rr_arb2: two-way round-robin chooser favouring the port that did not win last
module sram_rr_arb2
  import sram_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic valid,
  output logic winner
);
  assign valid  = req_a | req_b;
  assign winner = (req_a & req_b) ? ~last_grant : (req_b ? PORT_B : PORT_A);
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-port sequencer driving the async SRAM wrapper strobes
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W      = sram_pkg::ADDR_W,
  parameter int DATA_W      = sram_pkg::DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iA_REQ,
  input  logic              iA_WE,
  input  logic [ADDR_W-1:0] iA_ADDR,
  input  logic [1:0]        iA_BE_N,
  input  logic [DATA_W-1:0] iA_WDATA,
  output logic              oA_ACK,
  output logic [DATA_W-1:0] oA_RDATA,
  input  logic              iB_REQ,
  input  logic              iB_WE,
  input  logic [ADDR_W-1:0] iB_ADDR,
  input  logic [1:0]        iB_BE_N,
  input  logic [DATA_W-1:0] iB_WDATA,
  output logic              oB_ACK,
  output logic [DATA_W-1:0] oB_RDATA,
  output logic [ADDR_W-1:0] oSR_ADDR,
  output logic [1:0]        oSR_BE_N,
  output logic              oSR_CE_N,
  output logic              oSR_OE_N,
  output logic              oSR_WE_N,
  output logic [DATA_W-1:0] oSR_WDATA,
  input  logic [DATA_W-1:0] iSR_RDATA
);
  state_t state, state_n;
  logic [3:0] cnt;
  logic last_grant, cur_port, cur_we;
  logic arb_valid, arb_winner;
  logic grant, done;
  logic win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [1:0] win_be_n;
  logic [DATA_W-1:0] win_wdata;

  sram_rr_arb2 u_arb (
    .req_a      (iA_REQ),
    .req_b      (iB_REQ),
    .last_grant (last_grant),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  assign grant     = (state == IDLE) && arb_valid;
  assign done      = (state == ACCESS) && (cnt == 4'd0);
  assign win_we    = (arb_winner == PORT_B) ? iB_WE    : iA_WE;
  assign win_addr  = (arb_winner == PORT_B) ? iB_ADDR  : iA_ADDR;
  assign win_be_n  = (arb_winner == PORT_B) ? iB_BE_N  : iA_BE_N;
  assign win_wdata = (arb_winner == PORT_B) ? iB_WDATA : iA_WDATA;

  always_comb begin
    state_n = grant ? ACCESS : done ? RECOVER : (state == RECOVER) ? IDLE : state;
  end

  always_ff @(posedge iCLK) begin
    state <= iRST ? IDLE : state_n;
  end

  // ACK is a single-cycle pulse: set on the last strobe edge, cleared on the next
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oSR_ADDR   <= '0;
      oSR_WDATA  <= '0;
      oSR_BE_N   <= 2'b11;
      oSR_CE_N   <= 1'b1;
      oSR_OE_N   <= 1'b1;
      oSR_WE_N   <= 1'b1;
      oA_ACK     <= 1'b0;
      oB_ACK     <= 1'b0;
      oA_RDATA   <= '0;
      oB_RDATA   <= '0;
      cnt        <= '0;
      last_grant <= PORT_B;
      cur_port   <= PORT_A;
      cur_we     <= 1'b0;
    end else begin
      oA_ACK <= 1'b0;
      oB_ACK <= 1'b0;
      if (grant) begin
        oSR_ADDR   <= win_addr;
        oSR_BE_N   <= win_be_n;
        oSR_WDATA  <= win_wdata;
        oSR_CE_N   <= 1'b0;
        oSR_OE_N   <= win_we;
        oSR_WE_N   <= ~win_we;
        cnt        <= 4'(WAIT_CYCLES - 1);
        last_grant <= arb_winner;
        cur_port   <= arb_winner;
        cur_we     <= win_we;
      end else if (state == ACCESS) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          oSR_CE_N <= 1'b1;
          oSR_OE_N <= 1'b1;
          oSR_WE_N <= 1'b1;
          oSR_BE_N <= 2'b11;
          oA_ACK   <= (cur_port == PORT_A);
          oB_ACK   <= (cur_port == PORT_B);
          if (!cur_we && cur_port == PORT_A) oA_RDATA <= iSR_RDATA;
          if (!cur_we && cur_port == PORT_B) oB_RDATA <= iSR_RDATA;
        end
      end
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scoreboard bench for sram_arbiter with a behavioural SRAM
module tb_sram_arbiter
  import sram_pkg::*;
;
  localparam int W0 = 2;

  typedef struct {
    logic        p;
    logic        we;
    logic [17:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
    logic [15:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic a_req, a_we, b_req, b_we;
  logic [17:0] a_addr, b_addr;
  logic [1:0] a_be, b_be;
  logic [15:0] a_wd, b_wd;
  logic a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic [17:0] sr_addr;
  logic [1:0] sr_be_n;
  logic sr_ce_n, sr_oe_n, sr_we_n;
  logic [15:0] sr_wdata, sr_rdata;

  logic w_req;
  logic [17:0] w_addr;
  logic w_ack, w_b_ack;
  logic [15:0] w_rdata, w_b_rdata;
  logic [17:0] w_sr_addr;
  logic [1:0] w_sr_be_n;
  logic w_sr_ce_n, w_sr_oe_n, w_sr_we_n;
  logic [15:0] w_sr_wdata, w_sr_rdata;

  logic [15:0] mem [0:(1<<18)-1];
  logic [15:0] ref_mem [logic [17:0]];
  logic [15:0] last_rd [2];
  exp_t sbq[$];
  int gq[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, grant_cyc = 0, scnt = 0;
  logic prev_ce = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter #(.WAIT_CYCLES(W0)) u0 (
    .iCLK(clk), .iRST(rst),
    .iA_REQ(a_req), .iA_WE(a_we), .iA_ADDR(a_addr), .iA_BE_N(a_be), .iA_WDATA(a_wd),
    .oA_ACK(a_ack), .oA_RDATA(a_rdata),
    .iB_REQ(b_req), .iB_WE(b_we), .iB_ADDR(b_addr), .iB_BE_N(b_be), .iB_WDATA(b_wd),
    .oB_ACK(b_ack), .oB_RDATA(b_rdata),
    .oSR_ADDR(sr_addr), .oSR_BE_N(sr_be_n), .oSR_CE_N(sr_ce_n), .oSR_OE_N(sr_oe_n),
    .oSR_WE_N(sr_we_n), .oSR_WDATA(sr_wdata), .iSR_RDATA(sr_rdata)
  );

  sram_arbiter #(.WAIT_CYCLES(1)) u1 (
    .iCLK(clk), .iRST(rst),
    .iA_REQ(w_req), .iA_WE(1'b0), .iA_ADDR(w_addr), .iA_BE_N(2'b00), .iA_WDATA(16'h0),
    .oA_ACK(w_ack), .oA_RDATA(w_rdata),
    .iB_REQ(1'b0), .iB_WE(1'b0), .iB_ADDR(18'h0), .iB_BE_N(2'b11), .iB_WDATA(16'h0),
    .oB_ACK(w_b_ack), .oB_RDATA(w_b_rdata),
    .oSR_ADDR(w_sr_addr), .oSR_BE_N(w_sr_be_n), .oSR_CE_N(w_sr_ce_n), .oSR_OE_N(w_sr_oe_n),
    .oSR_WE_N(w_sr_we_n), .oSR_WDATA(w_sr_wdata), .iSR_RDATA(w_sr_rdata)
  );

  assign sr_rdata   = (!sr_ce_n && !sr_oe_n) ? mem[sr_addr] : 16'hDEAD;
  assign w_sr_rdata = (!w_sr_ce_n && !w_sr_oe_n) ? (w_sr_addr[15:0] ^ 16'h5A5A) : 16'hDEAD;

  // behavioural SRAM: byte-lane writes while CE and WE are low
  initial begin
    for (int i = 0; i < (1 << 18); i++) mem[i] = 16'h0;
    mem[18'h00010] = 16'h1234;
    mem[18'h3FFFF] = 16'h5566;
    mem[18'h00020] = 16'h2020;
    mem[18'h00030] = 16'h3030;
    forever begin
      @(posedge clk);
      if (!sr_ce_n && !sr_we_n) begin
        if (!sr_be_n[1]) mem[sr_addr][15:8] = sr_wdata[15:8];
        if (!sr_be_n[0]) mem[sr_addr][7:0]  = sr_wdata[7:0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  task automatic push(input logic p, input logic we, input logic [17:0] addr,
                      input logic [1:0] be, input logic [15:0] wd);
    exp_t e;
    logic [15:0] v;
    e.p = p; e.we = we; e.addr = addr; e.be = be; e.wd = wd;
    if (we) begin
      v = ref_rd(addr);
      if (!be[1]) v[15:8] = wd[15:8];
      if (!be[0]) v[7:0]  = wd[7:0];
      ref_mem[addr] = v;
    end else begin
      last_rd[p] = ref_rd(addr);
    end
    e.rd = last_rd[p];
    sbq.push_back(e);
  endtask

  task automatic xact(input logic p, input logic we, input logic [17:0] addr,
                      input logic [1:0] be, input logic [15:0] wd);
    logic got;
    got = 1'b0;
    if (p == PORT_A) begin a_we = we; a_addr = addr; a_be = be; a_wd = wd; a_req = 1'b1; end
    else begin b_we = we; b_addr = addr; b_be = be; b_wd = wd; b_req = 1'b1; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (p == PORT_A) ? a_ack : b_ack;
    end
    chk(p == PORT_A ? "a_ack_seen" : "b_ack_seen", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    if (p == PORT_A) a_req = 1'b0; else b_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
  endtask

  // monitor: strobe/address checks against the head of the scoreboard, ACK pops it
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      scnt = 0;
      prev_ce = 1'b1;
    end else begin
      if (!sr_ce_n) begin
        if (prev_ce) begin grant_cyc = cyc; gq.push_back(cyc); end
        scnt++;
        if (sbq.size() > 0) begin
          chk("sr_addr", {14'b0, sr_addr}, {14'b0, sbq[0].addr});
          chk("sr_be_n", {30'b0, sr_be_n}, {30'b0, sbq[0].be});
          chk("sr_oe_n", {31'b0, sr_oe_n}, {31'b0, sbq[0].we});
          chk("sr_we_n", {31'b0, sr_we_n}, {31'b0, !sbq[0].we});
          if (sbq[0].we) chk("sr_wdata", {16'b0, sr_wdata}, {16'b0, sbq[0].wd});
        end
      end
      if (a_ack || b_ack) begin
        chk("ack_excl", {31'b0, a_ack & b_ack}, 32'd0);
        if (sbq.size() == 0) begin
          chk("spurious_ack", {30'b0, a_ack, b_ack}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("ack_a", {31'b0, a_ack}, {31'b0, e.p == PORT_A});
          chk("ack_b", {31'b0, b_ack}, {31'b0, e.p == PORT_B});
          chk("rdata", {16'b0, (e.p == PORT_B) ? b_rdata : a_rdata}, {16'b0, e.rd});
          chk("ack_latency", cyc - grant_cyc, W0);
          chk("strobe_cycles", scnt, W0);
        end
        scnt = 0;
      end
      prev_ce = sr_ce_n;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_be = 2'b11; a_wd = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_be = 2'b11; b_wd = 0;
    w_req = 0; w_addr = 0;
    ref_mem[18'h00010] = 16'h1234;
    ref_mem[18'h3FFFF] = 16'h5566;
    ref_mem[18'h00020] = 16'h2020;
    ref_mem[18'h00030] = 16'h3030;
    do_reset();
    @(negedge clk);
    chk("rst_ce_n", {31'b0, sr_ce_n}, 32'd1);
    chk("rst_oe_n", {31'b0, sr_oe_n}, 32'd1);
    chk("rst_we_n", {31'b0, sr_we_n}, 32'd1);
    chk("rst_be_n", {30'b0, sr_be_n}, 32'd3);
    chk("rst_addr", {14'b0, sr_addr}, 32'd0);
    chk("rst_wdata", {16'b0, sr_wdata}, 32'd0);
    chk("rst_acks", {30'b0, a_ack, b_ack}, 32'd0);
    chk("rst_rdata", {a_rdata, b_rdata}, 32'd0);
    chk("rst_state", {30'b0, u0.state}, {30'b0, IDLE});
    @(posedge clk); #1;

    push(PORT_A, 0, 18'h00010, 2'b00, 16'h0);     xact(PORT_A, 0, 18'h00010, 2'b00, 16'h0);
    push(PORT_B, 1, 18'h3FFFF, 2'b01, 16'hABCD);  xact(PORT_B, 1, 18'h3FFFF, 2'b01, 16'hABCD);
    push(PORT_B, 0, 18'h3FFFF, 2'b00, 16'h0);     xact(PORT_B, 0, 18'h3FFFF, 2'b00, 16'h0);

    do_reset();
    gq.delete();
    push(PORT_A, 0, 18'h00010, 2'b00, 16'h0);
    push(PORT_B, 0, 18'h3FFFF, 2'b00, 16'h0);
    fork
      xact(PORT_A, 0, 18'h00010, 2'b00, 16'h0);
      xact(PORT_B, 0, 18'h3FFFF, 2'b00, 16'h0);
    join
    chk("grant_count", gq.size(), 2);
    if (gq.size() >= 2) chk("grant_gap", gq[1] - gq[0], W0 + 2);

    push(PORT_A, 0, 18'h00020, 2'b00, 16'h0);
    push(PORT_B, 0, 18'h3FFFF, 2'b00, 16'h0);
    push(PORT_A, 1, 18'h00040, 2'b00, 16'hC0DE);
    push(PORT_B, 0, 18'h00030, 2'b00, 16'h0);
    push(PORT_A, 0, 18'h00040, 2'b00, 16'h0);
    push(PORT_B, 1, 18'h00050, 2'b10, 16'hBEEF);
    fork
      begin
        xact(PORT_A, 0, 18'h00020, 2'b00, 16'h0);
        xact(PORT_A, 1, 18'h00040, 2'b00, 16'hC0DE);
        xact(PORT_A, 0, 18'h00040, 2'b00, 16'h0);
      end
      begin
        xact(PORT_B, 0, 18'h3FFFF, 2'b00, 16'h0);
        xact(PORT_B, 0, 18'h00030, 2'b00, 16'h0);
        xact(PORT_B, 1, 18'h00050, 2'b10, 16'hBEEF);
      end
    join
    chk("contention_drained", sbq.size(), 0);

    b_we = 1; b_addr = 18'h00060; b_be = 2'b00; b_wd = 16'h7777; b_req = 1;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = !sr_ce_n;
      end
      chk("abort_strobe_seen", {31'b0, seen}, 32'd1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    b_req = 0;
    @(negedge clk);
    chk("abort_ce_n", {31'b0, sr_ce_n}, 32'd1);
    chk("abort_oe_we", {30'b0, sr_oe_n, sr_we_n}, 32'd3);
    chk("abort_be_n", {30'b0, sr_be_n}, 32'd3);
    chk("abort_no_ack", {31'b0, b_ack}, 32'd0);
    chk("abort_state", {30'b0, u0.state}, {30'b0, IDLE});
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    push(PORT_B, 1, 18'h00060, 2'b00, 16'h7777);  xact(PORT_B, 1, 18'h00060, 2'b00, 16'h7777);
    push(PORT_B, 0, 18'h00060, 2'b00, 16'h0);     xact(PORT_B, 0, 18'h00060, 2'b00, 16'h0);
    push(PORT_B, 0, 18'h00050, 2'b00, 16'h0);     xact(PORT_B, 0, 18'h00050, 2'b00, 16'h0);

    push(PORT_A, 1, 18'h00010, 2'b11, 16'hFFFF);  xact(PORT_A, 1, 18'h00010, 2'b11, 16'hFFFF);
    push(PORT_A, 0, 18'h00010, 2'b00, 16'h0);     xact(PORT_A, 0, 18'h00010, 2'b00, 16'h0);

    w_addr = 18'h00123; w_req = 1;
    @(posedge clk);
    @(negedge clk);
    chk("w1_ce_n", {31'b0, w_sr_ce_n}, 32'd0);
    chk("w1_oe_we", {30'b0, w_sr_oe_n, w_sr_we_n}, 32'd1);
    chk("w1_addr", {14'b0, w_sr_addr}, 32'h123);
    chk("w1_be_wd", {14'b0, w_sr_be_n, w_sr_wdata}, 32'd0);
    chk("w1_ack_early", {31'b0, w_ack}, 32'd0);
    @(negedge clk);
    chk("w1_ack", {31'b0, w_ack}, 32'd1);
    chk("w1_ce_off", {31'b0, w_sr_ce_n}, 32'd1);
    chk("w1_rdata", {16'b0, w_rdata}, 32'h5B79);
    chk("w1_b_quiet", {15'b0, w_b_ack, w_b_rdata}, 32'd0);
    @(posedge clk); #1;
    w_req = 0;
    @(negedge clk);
    chk("w1_ack_pulse", {31'b0, w_ack}, 32'd0);

    repeat (4) @(posedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
